// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: the transmit scheduler
// state type, default scheduler parameters and the transmitter line
// constants used to size the completion watchdog.
// No ports (package).
package uart_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

    // Scheduler defaults
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 60000;

    // Transmitter line constants
    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD_RATE    = 9600;
    localparam int FRAME_BITS   = 10;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

    // Clock cycles needed for one complete frame on the line. A 10-bit
    // frame at 9600 baud on a 50 MHz clock is 52083 cycles, which is why
    // DEF_TIMEOUT sits a little above that.
    function automatic int frame_cycles(input int clk_hz, input int baud);
        return (clk_hz * FRAME_BITS) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_sched_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting
// one position after the last grant and wrapping at NREQ; the first set
// bit found wins.
// Ports:
//   req    in  NREQ          request vector
//   last   in  $clog2(NREQ)  index of the previous grant
//   winner out $clog2(NREQ)  index of the selected requester
//   valid  out 1             high when any request bit is set
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    valid
);

    localparam int IW = $clog2(NREQ);

    // Walk the candidates from lowest to highest priority so that the
    // highest-priority hit is the last one written. Offset NREQ is the
    // previous winner itself, which is therefore served last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin transmit scheduler sharing one UART transmitter between
// NREQ byte sources. It grants one pending requester, captures its byte,
// pulses the transmitter start, then waits for frame completion. A
// watchdog recovers if completion never arrives.
// Ports:
//   clk        in  1             clock, rising edge
//   rst        in  1             asynchronous reset, active low
//   req        in  NREQ          per-requester byte pending
//   req_data   in  NREQ*DW       requester i byte at [i*DW +: DW]
//   ack        out NREQ          one-hot pulse, granted byte captured
//   frame_done out NREQ          one-hot pulse, granted frame completed
//   tx_err     out 1             pulse on watchdog timeout
//   busy       out 1             high whenever not idle
//   grant_id   out $clog2(NREQ)  current or last grant index
//   tx_start   out 1             start pulse to the transmitter
//   tx_data    out DW            byte to the transmitter
//   tx_done    in  1             transmitter frame-complete pulse
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         frame_done,
    output logic                    tx_err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    tx_start,
    output logic [DW-1:0]           tx_data,
    input  logic                    tx_done
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_next;
    logic            wd_hit;
    logic [IW-1:0]   arb_winner;
    logic            arb_valid;
    logic [NREQ-1:0] grant_onehot;
    logic [DW-1:0]   req_bytes [NREQ];

    // Unpack the flat data bus so the winner's byte is a simple array read.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Watchdog increment saturates at TIMEOUT so it can never wrap back
    // into the valid range.
    always_comb begin
        wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CW'(1);
        wd_hit  = (wd_next == WD_LAST);
    end

    // Next-state logic. tx_done is only meaningful in WAIT and takes
    // priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done || wd_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, grant capture, watchdog and the registered
    // completion/error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= IW'(NREQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
            wd_cnt     <= '0;
            frame_done <= '0;
            tx_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= '0;
            tx_err     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        tx_data  <= req_bytes[arb_winner];
                        grant_id <= arb_winner;
                        last_q   <= arb_winner;
                    end
                end
                SEND: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_next;
                    if (tx_done) begin
                        frame_done <= grant_onehot;
                    end else if (wd_hit) begin
                        tx_err <= 1'b1;
                    end
                end
                default: begin
                    wd_cnt <= '0;
                end
            endcase
        end
    end

    // Start, acknowledge and busy are decoded straight from the state
    // register so they follow reset immediately.
    always_comb begin
        grant_onehot = NREQ'(1) << grant_id;
        tx_start     = (state_q == SEND);
        ack          = tx_start ? grant_onehot : '0;
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 120;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  frame_done;
    logic             tx_err;
    logic             busy;
    logic [1:0]       grant_id;
    logic             tx_start;
    logic [DW-1:0]    tx_data;
    logic             tx_done = 1'b0;

    logic [DW-1:0]    bytes [NREQ];

    int checks = 0;
    int errors = 0;
    int model_last = NREQ - 1;

    assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .frame_done (frame_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: rotate a doubled request vector so the
    // requester after the last grant lands at bit 0, take the lowest set bit
    function automatic int modelPick(input logic [3:0] r);
        logic [7:0] dbl;
        logic [7:0] rot;
        int start;
        start = (model_last + 1) % NREQ;
        dbl = {r, r};
        rot = dbl >> start;
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j]) return (start + j) % NREQ;
        end
        return -1;
    endfunction

    task automatic doReset();
        rst = 1'b0;
        req = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_last = NREQ - 1;
    endtask

    // One complete transaction: raise pattern at a negedge while idle,
    // check the SEND cycle, answer with tx_done after 'delay' WAIT cycles
    // and check the completion pulse. Optionally drop the winner's request
    // after ack and glitch req[1] during WAIT.
    task automatic applyStimulus(input logic [3:0] pattern, input int delay,
                                 input bit drop, input bit glitch, output int w);
        req = pattern;
        w = modelPick(pattern);
        @(negedge clk);
        checkOutput("send_tx_start", tx_start, 1);
        checkOutput("send_ack", ack, 32'(1) << w);
        checkOutput("send_tx_data", tx_data, bytes[w]);
        checkOutput("send_grant_id", grant_id, w);
        checkOutput("send_busy", busy, 1);
        model_last = w;
        if (drop) req[w] = 1'b0;
        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("wait_ack", ack, 0);
                checkOutput("wait_tx_start", tx_start, 0);
                checkOutput("wait_busy", busy, 1);
                if (glitch) req[1] = 1'b1;
            end
            if (k == 2 && glitch) req[1] = 1'b0;
        end
        checkOutput("wait_tx_data_stable", tx_data, bytes[w]);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checkOutput("done_frame_done", frame_done, 32'(1) << w);
        checkOutput("done_tx_err", tx_err, 0);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_ack", ack, 0);
    endtask

    initial begin
        int w;
        logic [3:0] pend;
        logic [3:0] newbits;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) bytes[i] = '0;

        // Reset state
        doReset();
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_tx_err", tx_err, 0);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_grant_id", grant_id, 0);

        // Stray tx_done while idle produces nothing
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        checkOutput("stray_frame_done", frame_done, 0);
        checkOutput("stray_tx_err", tx_err, 0);
        checkOutput("stray_busy", busy, 0);

        // Single request from requester 2
        $display("[TB] single request");
        bytes[2] = 8'hAA;
        applyStimulus(4'b0100, 100, 1'b1, 1'b0, w);
        checkOutput("single_grant", grant_id, 2);

        // Round robin with all four requesting continuously
        $display("[TB] round robin");
        doReset();
        for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 3 + i, 1'b0, 1'b0, w);
            checkOutput("rr_order", grant_id, exp_order[i]);
        end
        req = '0;
        @(negedge clk);

        // Watchdog: grant requester 1 and never complete
        $display("[TB] watchdog");
        bytes[1] = 8'h5C;
        req = 4'b0010;
        @(negedge clk);
        checkOutput("wd_ack", ack, 4'b0010);
        checkOutput("wd_tx_data", tx_data, 8'h5C);
        model_last = 1;
        req = '0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            checkOutput("wd_tx_err", tx_err, (k == TIMEOUT) ? 1 : 0);
            checkOutput("wd_frame_done", frame_done, 0);
            if (k == TIMEOUT) checkOutput("wd_busy_after", busy, 0);
        end

        // tx_done in the final timeout cycle wins over the watchdog
        $display("[TB] simultaneous done and timeout");
        bytes[3] = 8'h3E;
        applyStimulus(4'b1000, TIMEOUT - 1, 1'b1, 1'b0, w);
        @(negedge clk);
        checkOutput("simul_tx_err_after", tx_err, 0);

        // Withdrawn request pulsing while busy is never acked
        $display("[TB] withdrawn request");
        bytes[0] = 8'h81;
        applyStimulus(4'b0001, 6, 1'b1, 1'b1, w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("withdrawn_ack", ack, 0);
        end
        checkOutput("withdrawn_busy", busy, 0);

        // Randomized traffic against the reference model
        $display("[TB] random traffic");
        pend = '0;
        for (int it = 0; it < 20; it++) begin
            newbits = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (newbits[i] && !pend[i]) bytes[i] = 8'($urandom);
            end
            pend = pend | newbits;
            if (pend == 4'b0000) begin
                pend = 4'b0001;
                bytes[0] = 8'($urandom);
            end
            applyStimulus(pend, (it % 7 == 6) ? TIMEOUT - 1 : int'($urandom_range(1, 20)),
                          1'b1, 1'b0, w);
            pend[w] = 1'b0;
        end
        req = '0;
        @(negedge clk);

        // Reset asserted in WAIT clears everything immediately
        $display("[TB] reset mid-frame");
        bytes[2] = 8'hC3;
        req = 4'b0100;
        @(negedge clk);
        model_last = 2;
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ack", ack, 0);
        checkOutput("midrst_tx_start", tx_start, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        checkOutput("midrst_grant_id", grant_id, 0);
        checkOutput("midrst_frame_done", frame_done, 0);
        checkOutput("midrst_tx_err", tx_err, 0);
        @(negedge clk);
        rst = 1'b1;
        model_last = NREQ - 1;
        @(negedge clk);
        checkOutput("postrst_frame_done", frame_done, 0);
        bytes[0] = 8'h11;
        bytes[3] = 8'h99;
        applyStimulus(4'b1001, 8, 1'b1, 1'b0, w);
        checkOutput("ptr_reset_grant", grant_id, 0);
        applyStimulus(4'b1000, 4, 1'b1, 1'b0, w);
        checkOutput("ptr_reset_next", grant_id, 3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
